// File: rtl/video_spi_capture.sv
// video_spi_capture: reads SAMPLE_W-bit words from the video SPI, packs them
// into 2 bytes each and serves one buffered message to cmd_encoder.
// Ports: clk, rst (sync, active-high); video SPI n_cs/sclk/miso;
//   command in_data/in_ena; reader enc_rdreq/out_data/have_msg/len; busy.
// Build option: define VIDEO_CRC_EN to append an XOR check byte.
module video_spi_capture #(
  parameter int SAMPLE_W = 12,
  parameter int CLK_DIV  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       n_cs,
  output logic       sclk,
  input  logic       miso,
  input  logic [7:0] in_data,
  input  logic       in_ena,
  input  logic       enc_rdreq,
  output logic [7:0] out_data,
  output logic       have_msg,
  output logic [7:0] len,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_PACK  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;

  localparam logic [15:0] DIV_END = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_END = 16'(CS_GAP - 1);
  localparam logic [4:0]  BIT_END = 5'(SAMPLE_W - 1);

  logic [2:0]          state;
  logic [15:0]         tcnt;
  logic [4:0]          bit_cnt;
  logic [SAMPLE_W-1:0] shreg;
  logic [6:0]          n_req;
  logic [6:0]          s_cnt;
  logic [7:0]          wr_ptr;
  logic [7:0]          rd_ptr;
  logic [7:0]          mem [256];
  logic                we;
  logic [7:0]          wdata;
  logic [15:0]         word16;
`ifdef VIDEO_CRC_EN
  logic [7:0]          crc;
`endif

  assign busy   = (state != S_IDLE);
  // Sample zero-padded at the top so the hi byte carries the MSBs.
  assign word16 = 16'(shreg);

  always_comb begin
    we    = 1'b0;
    wdata = 8'h00;
    if (state == S_PACK) begin
      we    = 1'b1;
      wdata = tcnt[0] ? word16[7:0] : word16[15:8];
    end
`ifdef VIDEO_CRC_EN
    if (state == S_DONE && !tcnt[0]) begin
      we    = 1'b1;
      wdata = crc;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      n_cs     <= 1'b1;
      sclk     <= 1'b0;
      have_msg <= 1'b0;
      len      <= 8'h00;
      out_data <= 8'h00;
      tcnt     <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      n_req    <= '0;
      s_cnt    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
`ifdef VIDEO_CRC_EN
      crc      <= '0;
`endif
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + 8'd1;
`ifdef VIDEO_CRC_EN
        crc    <= crc ^ wdata;
`endif
      end
      case (state)
        S_IDLE: begin
          if (in_ena && !in_data[7] && in_data[6:0] != 7'd0) begin
            n_req  <= in_data[6:0];
            s_cnt  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
`ifdef VIDEO_CRC_EN
            crc    <= '0;
`endif
            tcnt   <= '0;
            n_cs   <= 1'b0;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tcnt == DIV_END) begin
            tcnt    <= '0;
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_SHIFT: begin
          if (tcnt == DIV_END) begin
            tcnt <= '0;
            if (!sclk) begin
              // capture on the cycle sclk is driven high
              sclk  <= 1'b1;
              shreg <= SAMPLE_W'({shreg, miso});
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == BIT_END) begin
                n_cs  <= 1'b1;
                state <= S_PACK;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_PACK: begin
          if (!tcnt[0]) begin
            tcnt <= 16'd1;
          end else begin
            tcnt  <= '0;
            s_cnt <= s_cnt + 7'd1;
            if (s_cnt + 7'd1 < n_req) state <= S_GAP;
            else                      state <= S_DONE;
          end
        end
        S_GAP: begin
          if (tcnt == GAP_END) begin
            tcnt  <= '0;
            n_cs  <= 1'b0;
            state <= S_SETUP;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_DONE: begin
`ifdef VIDEO_CRC_EN
          if (!tcnt[0]) begin
            tcnt <= 16'd1;
          end else begin
            tcnt     <= '0;
            len      <= wr_ptr;
            have_msg <= 1'b1;
            out_data <= mem[0];
            state    <= S_DRAIN;
          end
`else
          len      <= wr_ptr;
          have_msg <= 1'b1;
          out_data <= mem[0];
          state    <= S_DRAIN;
`endif
        end
        S_DRAIN: begin
          if (enc_rdreq) begin
            rd_ptr <= rd_ptr + 8'd1;
            // last byte: out_data keeps showing it
            if (rd_ptr + 8'd1 == len) begin
              have_msg <= 1'b0;
              state    <= S_IDLE;
            end else begin
              out_data <= mem[rd_ptr + 8'd1];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_spi_capture.sv
// tb_video_spi_capture: directed bench for video_spi_capture with an SPI
// slave model; a second instance runs CLK_DIV=3, CS_GAP=1.
module tb_video_spi_capture;

`ifdef VIDEO_CRC_EN
  localparam int CRC = 1;
`else
  localparam int CRC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       miso = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ena = 1'b0;
  logic       enc_rdreq = 1'b0;
  logic       n_cs, sclk, have_msg, busy;
  logic [7:0] out_data, len;

  logic       in_ena6 = 1'b0;
  logic [7:0] in_data6 = 8'h00;
  logic       rdreq6 = 1'b0;
  logic       miso6 = 1'b0;
  logic       n_cs6, sclk6, have6, busy6;
  logic [7:0] out6, len6;

  int checks = 0;
  int errors = 0;
  logic [11:0] words [128];
  int rises = 0;
  int base = 0;
  int ncs_lows = 0;

  video_spi_capture dut (
    .clk(clk), .rst(rst), .n_cs(n_cs), .sclk(sclk), .miso(miso),
    .in_data(in_data), .in_ena(in_ena), .enc_rdreq(enc_rdreq),
    .out_data(out_data), .have_msg(have_msg), .len(len), .busy(busy)
  );

  video_spi_capture #(.SAMPLE_W(12), .CLK_DIV(3), .CS_GAP(1)) dut6 (
    .clk(clk), .rst(rst), .n_cs(n_cs6), .sclk(sclk6), .miso(miso6),
    .in_data(in_data6), .in_ena(in_ena6), .enc_rdreq(rdreq6),
    .out_data(out6), .have_msg(have6), .len(len6), .busy(busy6)
  );

  always #5 clk = ~clk;

  always @(posedge sclk) rises++;
  always @(negedge n_cs) ncs_lows++;

  // slave: present bit number (rises-base) of the word stream, MSB first
  always @(negedge clk) begin
    int idx;
    idx = rises - base;
    if (idx >= 0 && idx < 128 * 12) miso = words[idx / 12][11 - idx % 12];
    else miso = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_data = b;
    in_ena = 1'b1;
    base = rises;
    tick();
    in_ena = 1'b0;
  endtask

  task automatic wait_msg(input string tag, input int bound);
    int k;
    k = 0;
    while (!have_msg && k < bound) begin
      tick();
      k++;
    end
    chk(tag, 32'(have_msg), 1);
  endtask

  task automatic drain(input string tag, input int n, input bit probe);
    logic [7:0] e[$];
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      e.push_back({4'h0, words[i][11:8]});
      e.push_back(words[i][7:0]);
    end
    foreach (e[i]) x = x ^ e[i];
    if (CRC == 1) e.push_back(x);
    chk({tag, "_len"}, 32'(len), 32'(e.size()));
    enc_rdreq = 1'b1;
    for (int k = 0; k < e.size(); k++) begin
      chk($sformatf("%s_b%0d", tag, k), 32'(out_data), 32'(e[k]));
      if (probe && k == e.size() - 1) begin
        in_data = 8'h01;
        in_ena = 1'b1;
      end
      tick();
      in_ena = 1'b0;
    end
    enc_rdreq = 1'b0;
    chk({tag, "_have_end"}, 32'(have_msg), 0);
    chk({tag, "_busy_end"}, 32'(busy), 0);
  endtask

  bit sc [400];
  bit cs [400];

  initial begin
    int c0, t_end, hr, nh, bad, lr, lows, ch, cs_runs, cs_len;
    bit lv, seen;
    logic [7:0] t2 [5];
    t2[0] = 8'h0A; t2[1] = 8'hBC; t2[2] = 8'h01; t2[3] = 8'h23;
    t2[4] = 8'h94;
    foreach (words[i]) words[i] = 12'h000;

    repeat (3) tick();
    chk("rst_ncs", 32'(n_cs), 1);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_have", 32'(have_msg), 0);
    chk("rst_len", 32'(len), 0);
    chk("rst_out", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    // reset in the middle of a 5-sample shift
    send(8'h05);
    repeat (10) tick();
    chk("t1_busy_mid", 32'(busy), 1);
    chk("t1_ncs_mid", 32'(n_cs), 0);
    rst = 1'b1;
    tick();
    chk("t1_ncs", 32'(n_cs), 1);
    chk("t1_sclk", 32'(sclk), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_have", 32'(have_msg), 0);
    rst = 1'b0;
    tick();
    words[0] = 12'h5A5;
    send(8'h01);
    wait_msg("t1_msg", 200);
    chk("t1_rises", 32'(rises - base), 12);
    drain("t1", 1, 1'b0);

    // two samples
    words[0] = 12'hABC;
    words[1] = 12'h123;
    c0 = ncs_lows;
    send(8'h02);
    wait_msg("t2_msg", 400);
    chk("t2_rises", 32'(rises - base), 24);
    chk("t2_ncs_lows", 32'(ncs_lows - c0), 2);
    chk("t2_len", 32'(len), 32'(4 + CRC));
    for (int k = 0; k < 4 + CRC; k++) begin
      chk($sformatf("t2_byte%0d", k), 32'(out_data), 32'(t2[k]));
      enc_rdreq = 1'b1;
      tick();
      enc_rdreq = 1'b0;
      if (k < 3 + CRC) chk("t2_have_mid", 32'(have_msg), 1);
    end
    chk("t2_have_end", 32'(have_msg), 0);
    chk("t2_busy_end", 32'(busy), 0);

    // ignored commands and pops
    c0 = ncs_lows;
    send(8'h00);
    repeat (3) tick();
    chk("t4_cmd00_busy", 32'(busy), 0);
    send(8'h85);
    repeat (3) tick();
    chk("t4_cmd85_busy", 32'(busy), 0);
    chk("t4_ncs_idle", 32'(ncs_lows - c0), 0);
    enc_rdreq = 1'b1;
    tick();
    enc_rdreq = 1'b0;
    chk("t4_out_hold", 32'(out_data), 32'(t2[3 + CRC]));
    chk("t4_have_hold", 32'(have_msg), 0);
    words[0] = 12'h3C7;
    send(8'h01);
    wait_msg("t4_msg", 200);
    c0 = ncs_lows;
    send(8'h01);
    chk("t4_drain_busy", 32'(busy), 1);
    chk("t4_drain_have", 32'(have_msg), 1);
    repeat (5) tick();
    chk("t4_drain_ncs", 32'(ncs_lows - c0), 0);
    drain("t4", 1, 1'b0);

    // full-length message, continuous pops
    for (int i = 0; i < 128; i++) words[i] = 12'(i * 397 + 21);
    send(8'h7F);
    wait_msg("t5_msg", 8000);
    chk("t5_rises", 32'(rises - base), 127 * 12);
    drain("t5", 127, 1'b1);
    chk("t5_len_hold", 32'(len), 32'(254 + CRC));
    send(8'h01);
    chk("t5_accept", 32'(busy), 1);
    wait_msg("t5_msg2", 200);
    drain("t5b", 1, 1'b0);

    // CLK_DIV=3, CS_GAP=1 timing
    in_data6 = 8'h02;
    in_ena6 = 1'b1;
    tick();
    in_ena6 = 1'b0;
    t_end = 0;
    for (int t = 0; t < 400; t++) begin
      sc[t] = sclk6;
      cs[t] = n_cs6;
      t_end = t;
      if (have6) break;
      tick();
    end
    chk("t6_have", 32'(have6), 1);
    hr = 0; nh = 0; bad = 0; lr = 0; lows = 0; lv = 1'b0;
    ch = 0; cs_runs = 0; cs_len = 0; seen = 1'b0;
    for (int t = 0; t <= t_end; t++) begin
      if (sc[t]) hr++;
      else begin
        if (hr > 0) begin
          nh++;
          if (hr != 3) bad++;
        end
        hr = 0;
      end
      if (t > 0) begin
        if (!sc[t] && sc[t-1]) begin
          lv = 1'b1;
          lr = 0;
        end
        if (!sc[t]) begin
          lr++;
          if (cs[t]) lv = 1'b0;
        end
        if (sc[t] && !sc[t-1] && lv) begin
          lows++;
          if (lr != 3) bad++;
          lv = 1'b0;
        end
      end
      if (cs[t]) ch++;
      else begin
        if (ch > 0 && seen) begin
          cs_runs++;
          cs_len = ch;
        end
        seen = 1'b1;
        ch = 0;
      end
    end
    chk("t6_high_runs", 32'(nh), 24);
    chk("t6_low_runs", 32'(lows), 22);
    chk("t6_bad_runs", 32'(bad), 0);
    chk("t6_cs_runs", 32'(cs_runs), 1);
    chk("t6_cs_gap", 32'(cs_len), 3);
    chk("t6_len", 32'(len6), 32'(4 + CRC));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
